// File: rtl/div_request_sequencer_if.sv
// Handshake and divider-bus bundle between a requester, the sequencer and the divider.
interface div_request_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int TAGW  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_dividend;
  logic [WIDTH-1:0] in_divisor;
  logic [TAGW-1:0]  in_tag;
  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_ready;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic [WIDTH-1:0] out_remainder;
  logic [TAGW-1:0]  out_tag;
  logic             out_dbz;
  logic             out_timeout;
  logic             busy;

  // Sequencer side.
  modport slave (
    input  in_valid, in_dividend, in_divisor, in_tag,
    input  div_ready, div_quotient, div_remainder, out_ready,
    output in_ready, div_start, div_dividend, div_divisor,
    output out_valid, out_quotient, out_remainder, out_tag, out_dbz, out_timeout, busy
  );

  // Requester / divider / consumer side.
  modport master (
    output in_valid, in_dividend, in_divisor, in_tag,
    output div_ready, div_quotient, div_remainder, out_ready,
    input  in_ready, div_start, div_dividend, div_divisor,
    input  out_valid, out_quotient, out_remainder, out_tag, out_dbz, out_timeout, busy
  );
endinterface

// File: rtl/div_request_sequencer.sv
// Front end for the restoring divider: accepts a request, screens divide-by-zero,
// starts the divider, waits for its result under a watchdog and presents it downstream.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request; operands and tag latched on acceptance
// ISSUE   | div_start high until the divider is seen idle
// WAIT_LO | waiting for the divider to leave its idle state
// WAIT_HI | waiting for the divider to come back with a result
// OUT     | result (or dbz / timeout outcome) held until out_ready
module div_request_sequencer #(
  parameter int WIDTH   = 8,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 64,
  parameter int CNTW    = 7
) (
  input logic clk,
  input logic rst,
  div_request_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_OUT     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] dividend_q, divisor_q, quot_q, rem_q;
  logic [TAGW-1:0]  tag_q;
  logic             dbz_q, timeout_q;
  logic [CNTW-1:0]  wd_cnt;
  logic             wd_done, accept, capture, abort;
  logic             in_ready, div_start, out_valid;

  assign wd_done = (wd_cnt == CNTW'(TIMEOUT - 1));

  // State register; rst aborts any request in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and Moore handshake outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    in_ready  = 1'b0;
    div_start = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = (bus.in_divisor == '0) ? S_OUT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start = 1'b1;
        if (bus.div_ready) state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (wd_done) begin
          abort     = 1'b1;
          state_nxt = S_OUT;
        end else if (!bus.div_ready) begin
          state_nxt = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        // A result arriving on the last watchdog cycle still wins over the abort.
        if (bus.div_ready) begin
          capture   = 1'b1;
          state_nxt = S_OUT;
        end else if (wd_done) begin
          abort     = 1'b1;
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand/tag latch, result capture and outcome flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      tag_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      dbz_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (accept) begin
      dividend_q <= bus.in_dividend;
      divisor_q  <= bus.in_divisor;
      tag_q      <= bus.in_tag;
      dbz_q      <= (bus.in_divisor == '0);
      timeout_q  <= 1'b0;
      if (bus.in_divisor == '0) begin
        quot_q <= '1;
        rem_q  <= bus.in_dividend;
      end
    end else if (capture) begin
      quot_q <= bus.div_quotient;
      rem_q  <= bus.div_remainder;
    end else if (abort) begin
      quot_q    <= '0;
      rem_q     <= '0;
      timeout_q <= 1'b1;
    end
  end

  // Watchdog: cleared when the divider takes the start, counts through both wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          wd_cnt <= '0;
    else if (state == S_ISSUE && bus.div_ready)       wd_cnt <= '0;
    else if (state == S_WAIT_LO || state == S_WAIT_HI) wd_cnt <= wd_cnt + CNTW'(1);
  end

  assign bus.in_ready      = in_ready;
  assign bus.div_start     = div_start;
  assign bus.div_dividend  = dividend_q;
  assign bus.div_divisor   = divisor_q;
  assign bus.out_valid     = out_valid;
  assign bus.out_quotient  = quot_q;
  assign bus.out_remainder = rem_q;
  assign bus.out_tag       = tag_q;
  assign bus.out_dbz       = dbz_q;
  assign bus.out_timeout   = timeout_q;
  assign bus.busy          = (state != S_IDLE);

endmodule

// File: tb/tb_div_request_sequencer.sv
// Scoreboard bench for div_request_sequencer with a behavioural divider model.
module tb_div_request_sequencer;
  localparam int WIDTH = 8, TAGW = 4, TIMEOUT = 64, CNTW = 7, RUN = 10;

  typedef struct {
    logic [7:0] q, r;
    logic [3:0] tag;
    logic       dbz, to;
    int         lat;
    int         acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hang = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   first_seen = 0;
  int   pop_by_tag[16];
  int   acc_by_tag[16];

  div_request_sequencer_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();

  div_request_sequencer #(.WIDTH(WIDTH), .TAGW(TAGW), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Divider model: takes the start only when idle, ready low for RUN cycles, garbage while busy.
  logic [7:0] m_a, m_b;
  int         m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.div_ready     <= 1'b1;
      bus.div_quotient  <= 8'h00;
      bus.div_remainder <= 8'h00;
      m_cnt             <= 0;
    end else if (bus.div_ready && bus.div_start) begin
      bus.div_ready     <= 1'b0;
      m_a               <= bus.div_dividend;
      m_b               <= bus.div_divisor;
      bus.div_quotient  <= 8'h5A;
      bus.div_remainder <= 8'hA5;
      m_cnt             <= RUN;
    end else if (!bus.div_ready && !hang) begin
      if (m_cnt <= 1) begin
        bus.div_ready     <= 1'b1;
        bus.div_quotient  <= m_a / m_b;
        bus.div_remainder <= m_a % m_b;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Monitor: compares every presented result against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.div_start) starts++;
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got q=%0d r=%0d tag=%0d, expected no output", bus.out_quotient, bus.out_remainder, bus.out_tag);
        end else begin
          mon_e = sb[0];
          if (!first_seen) begin
            first_seen = 1;
            if (mon_e.lat >= 0) chk("latency", cyc - mon_e.acc, mon_e.lat);
          end
          chk("quotient", bus.out_quotient, mon_e.q);
          chk("remainder", bus.out_remainder, mon_e.r);
          chk("tag", bus.out_tag, mon_e.tag);
          chk("dbz", bus.out_dbz, mon_e.dbz);
          chk("timeout", bus.out_timeout, mon_e.to);
          chk("in_ready_in_out", bus.in_ready, 1'b0);
          if (bus.out_ready) begin
            void'(sb.pop_front());
            first_seen = 0;
            pop_by_tag[mon_e.tag] = cyc;
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] dvd, input logic [7:0] dvs, input logic [3:0] tag,
                      input bit push, input logic [7:0] eq, input logic [7:0] er,
                      input logic edbz, input logic eto, input int lat);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    bus.in_valid    = 1'b1;
    bus.in_dividend = dvd;
    bus.in_divisor  = dvs;
    bus.in_tag      = tag;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: tag %0d not accepted, expected acceptance within 300 cycles", tag);
      bus.in_valid = 1'b0;
      return;
    end
    acc_by_tag[tag] = cyc;
    e.q = eq; e.r = er; e.tag = tag; e.dbz = edbz; e.to = eto; e.lat = lat; e.acc = cyc;
    @(posedge clk); #1;
    if (push) sb.push_back(e);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    end
  endtask

  int s0;

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_dividend = '0;
    bus.in_divisor  = '0;
    bus.in_tag      = '0;
    bus.out_ready   = 1'b1;
    #12;
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_div_start", bus.div_start, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_out_q", bus.out_quotient, 8'd0);
    chk("rst_out_r", bus.out_remainder, 8'd0);
    chk("rst_out_flags", {bus.out_tag, bus.out_dbz, bus.out_timeout}, 6'd0);
    chk("rst_div_ops", {bus.div_dividend, bus.div_divisor}, 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    s0 = starts;
    send(8'd100, 8'd7, 4'd3, 1, 8'd14, 8'd2, 1'b0, 1'b0, -1);
    drain();
    chk("start_pulses_100_7", starts - s0, 1);

    send(8'd0,   8'd5, 4'd1, 1, 8'd0,   8'd0, 1'b0, 1'b0, -1);
    send(8'd255, 8'd1, 4'd2, 1, 8'd255, 8'd0, 1'b0, 1'b0, -1);
    send(8'd5,   8'd9, 4'd8, 1, 8'd0,   8'd5, 1'b0, 1'b0, -1);
    drain();

    s0 = starts;
    send(8'd37, 8'd0, 4'd9, 1, 8'hFF, 8'd37, 1'b1, 1'b0, 1);
    drain();
    chk("start_pulses_dbz", starts - s0, 0);

    hang = 1'b1;
    send(8'd50, 8'd5, 4'd4, 1, 8'd0, 8'd0, 1'b0, 1'b1, 2 + TIMEOUT);
    drain();
    hang = 1'b0;
    repeat (RUN + 2) @(posedge clk);
    #1;

    bus.out_ready = 1'b0;
    fork
      begin
        send(8'd200, 8'd9, 4'd5, 1, 8'd22, 8'd2, 1'b0, 1'b0, -1);
        send(8'd9,   8'd3, 4'd6, 1, 8'd3,  8'd0, 1'b0, 1'b0, -1);
      end
      begin
        int n = 0;
        @(posedge clk); #1;
        while (!bus.out_valid && n < 300) begin
          @(posedge clk); #1;
          n++;
        end
        if (n >= 300) begin
          checks++;
          errors++;
          $display("FAIL backpressure_wait: got out_valid=0, expected 1 within 300 cycles");
        end
        repeat (10) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("back_to_back_accept", acc_by_tag[6], pop_by_tag[5] + 1);

    send(8'd10, 8'd3, 4'd7, 0, 8'd0, 8'd0, 1'b0, 1'b0, -1);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_in_wait_hi", {bus.busy, bus.div_ready}, 2'b10);
    rst = 1'b1;
    #1;
    chk("async_rst_in_ready", bus.in_ready, 1'b1);
    chk("async_rst_out_valid", bus.out_valid, 1'b0);
    chk("async_rst_div_start", bus.div_start, 1'b0);
    chk("async_rst_busy", bus.busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    send(8'd81, 8'd9, 4'd10, 1, 8'd9, 8'd0, 1'b0, 1'b0, -1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // Absolute guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation time %0t, expected completion earlier", $time);
    $fatal(1, "global timeout");
  end
endmodule
